// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FP operation sequencer.
// Holds the FP opcode field values, the FP unit operation encoding, the
// sequencer state encoding and the opcode decoder used by the top level.
package fpu_seq_pkg;

  localparam logic [5:0] OP_ADD_S = 6'b100010;
  localparam logic [5:0] OP_SUB_S = 6'b100011;
  localparam logic [5:0] OP_MUL_S = 6'b100100;

  typedef enum logic [1:0] {
    FU_ADD = 2'b00,
    FU_SUB = 2'b01,
    FU_MUL = 2'b10
  } fu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } seq_state_e;

  typedef struct packed {
    logic   legal;
    fu_op_e op;
  } op_dec_t;

  // Map an instruction opcode onto an FP unit operation; unknown opcodes
  // come back with legal cleared.
  function automatic op_dec_t decode_op(input logic [5:0] opcode);
    op_dec_t d;
    d.legal = 1'b1;
    d.op    = FU_ADD;
    case (opcode)
      OP_ADD_S: d.op = FU_ADD;
      OP_SUB_S: d.op = FU_SUB;
      OP_MUL_S: d.op = FU_MUL;
      default:  d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fpr_wr_arbiter.sv
// Single FPR write-port arbiter.
// Writeback from the sequencer always wins; an mtc1 request is granted only
// in cycles without a writeback and must be held by the requester otherwise.
// Ports:
//   wb_valid_i / wb_addr_i / wb_data_i    : sequencer writeback
//   ext_req_i / ext_addr_i / ext_data_i   : CPU mtc1 write request
//   ext_gnt_o                             : mtc1 write taken this cycle
//   we_o / waddr_o / wdata_o              : FPR write port
module fpr_wr_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          wb_valid_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic          ext_req_i,
  input  logic [AW-1:0] ext_addr_i,
  input  logic [DW-1:0] ext_data_i,
  output logic          ext_gnt_o,
  output logic          we_o,
  output logic [AW-1:0] waddr_o,
  output logic [DW-1:0] wdata_o
);

  always_comb begin
    ext_gnt_o = ext_req_i && !wb_valid_i;
    we_o      = wb_valid_i || ext_gnt_o;
    waddr_o   = '0;
    wdata_o   = '0;
    if (wb_valid_i) begin
      waddr_o = wb_addr_i;
      wdata_o = wb_data_i;
    end else if (ext_gnt_o) begin
      waddr_o = ext_addr_i;
      wdata_o = ext_data_i;
    end
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Multi-cycle controller between CPU decode and a shared fixed-latency FP unit.
// Accepts one add.s/sub.s/mul.s per handshake, pulses fu_start, times the unit
// latency, captures the result and writes it back through the shared FPR port.
// Ports:
//   clk, rst (async, active low)
//   iss_*            : instruction issue handshake and operands
//   fu_*             : FP unit start, operation, operands and result
//   ext_wr_*         : CPU mtc1 write request / grant
//   fpr_*            : FPR write port
//   chk_addr_a/b     : source indices checked against the pending destination
//   hazard, busy     : CPU stall flags
//   illegal_op       : pulse after an unsupported opcode is accepted
module fpu_op_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned ADD_LAT = 2,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [5:0]    iss_opcode,
  input  logic [AW-1:0] iss_rd,
  input  logic [DW-1:0] iss_a,
  input  logic [DW-1:0] iss_b,
  output logic          fu_start,
  output logic [1:0]    fu_op,
  output logic [DW-1:0] fu_a,
  output logic [DW-1:0] fu_b,
  input  logic [DW-1:0] fu_result,
  input  logic          ext_wr_req,
  input  logic [AW-1:0] ext_wr_addr,
  input  logic [DW-1:0] ext_wr_data,
  output logic          ext_wr_gnt,
  output logic          fpr_we,
  output logic [AW-1:0] fpr_waddr,
  output logic [DW-1:0] fpr_wdata,
  input  logic [AW-1:0] chk_addr_a,
  input  logic [AW-1:0] chk_addr_b,
  output logic          hazard,
  output logic          busy,
  output logic          illegal_op
);

  // Counter holds LAT-1 at entry to EXEC and leaves on reaching zero.
  localparam logic [3:0] AddCnt = 4'(ADD_LAT - 1);
  localparam logic [3:0] MulCnt = 4'(MUL_LAT - 1);

  seq_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  fu_op_e        op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] a_q, b_q, res_q;
  logic          pend_valid_q;
  logic          start_q;
  logic          illegal_q;

  op_dec_t dec;
  logic    accept;
  logic    wb_valid;

  assign dec    = decode_op(iss_opcode);
  assign accept = iss_valid && iss_ready;

  // State register and datapath latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= FU_ADD;
      rd_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      pend_valid_q <= 1'b0;
      start_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= accept && dec.legal;
      illegal_q <= accept && !dec.legal;
      if (accept && dec.legal) begin
        op_q         <= dec.op;
        rd_q         <= iss_rd;
        a_q          <= iss_a;
        b_q          <= iss_b;
        pend_valid_q <= 1'b1;
      end else if (state_q == WB) begin
        pend_valid_q <= 1'b0;
      end
      if (state_q == EXEC && cnt_q == 4'd0) begin
        res_q <= fu_result;
      end
    end
  end

  // Next-state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && dec.legal) begin
          state_d = EXEC;
          cnt_d   = (dec.op == FU_MUL) ? MulCnt : AddCnt;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = WB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    iss_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    wb_valid  = (state_q == WB);
  end

  assign fu_start   = start_q;
  assign fu_op      = op_q;
  assign fu_a       = a_q;
  assign fu_b       = b_q;
  assign illegal_op = illegal_q;

  // No bypass: sources matching the pending destination stall through WB.
  assign hazard = pend_valid_q && ((chk_addr_a == rd_q) || (chk_addr_b == rd_q));

  fpr_wr_arbiter #(
    .DW (DW),
    .AW (AW)
  ) u_wr_arb (
    .wb_valid_i (wb_valid),
    .wb_addr_i  (rd_q),
    .wb_data_i  (res_q),
    .ext_req_i  (ext_wr_req),
    .ext_addr_i (ext_wr_addr),
    .ext_data_i (ext_wr_data),
    .ext_gnt_o  (ext_wr_gnt),
    .we_o       (fpr_we),
    .waddr_o    (fpr_waddr),
    .wdata_o    (fpr_wdata)
  );

endmodule
